// File: rtl/uart_rx_loader.sv
// Serial 8N1-style receiver feeding a parallel load register: N-bit word plus one-cycle load
// strobe on a good frame, one-cycle frame_err strobe when the stop bit samples low.
module uart_rx_loader #(
   parameter int unsigned N            = 8,
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         rx,
   output logic [N-1:0] data,
   output logic         load,
   output logic         frame_err,
   output logic         busy
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned BW = $clog2(N + 1);

   localparam logic [CW-1:0] DivLast = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] DivHalf = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] BitLast = BW'(N - 1);

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } state_e;

   state_e          state_q;
   logic            rx_meta_q;
   logic            rx_s_q;
   logic            rx_d_q;
   logic [CW-1:0]   div_q;
   logic [BW-1:0]   bit_q;
   logic [N-1:0]    shreg_q;
   logic [N-1:0]    data_q;
   logic            load_q;
   logic            ferr_q;
   logic [N:0]      shift_in;

   // New bit enters at the top so that after N shifts bit k sits in shreg[k].
   always_comb begin
      shift_in = {rx_s_q, shreg_q};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_d_q    <= 1'b1;
         div_q     <= '0;
         bit_q     <= '0;
         shreg_q   <= '0;
         data_q    <= '0;
         load_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         rx_d_q    <= rx_s_q;
         load_q    <= 1'b0;
         ferr_q    <= 1'b0;
         case (state_q)
            StIdle: begin
               if (rx_d_q && !rx_s_q) begin
                  state_q <= StStart;
                  div_q   <= '0;
               end
            end
            StStart: begin
               if (div_q == DivHalf) begin
                  div_q   <= '0;
                  bit_q   <= '0;
                  state_q <= rx_s_q ? StIdle : StData;
               end else begin
                  div_q <= div_q + CW'(1);
               end
            end
            StData: begin
               if (div_q == DivLast) begin
                  div_q   <= '0;
                  shreg_q <= shift_in[N:1];
                  if (bit_q == BitLast) begin
                     state_q <= StStop;
                  end else begin
                     bit_q <= bit_q + BW'(1);
                  end
               end else begin
                  div_q <= div_q + CW'(1);
               end
            end
            StStop: begin
               if (div_q == DivLast) begin
                  div_q   <= '0;
                  state_q <= StIdle;
                  if (rx_s_q) begin
                     data_q <= shreg_q;
                     load_q <= 1'b1;
                  end else begin
                     ferr_q <= 1'b1;
                  end
               end else begin
                  div_q <= div_q + CW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign data      = data_q;
   assign load      = load_q;
   assign frame_err = ferr_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_loader.sv
// Directed bench for uart_rx_loader: a table of frames plus hand sequences for glitch,
// back-to-back, mid-frame reset and a narrow (N=5) instance.
module tb_uart_rx_loader;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic       rx5 = 1'b1;
   logic [7:0] data;
   logic       load, frame_err, busy;
   logic [4:0] data5;
   logic       load5, frame_err5, busy5;

   always #5 clk = ~clk;

   uart_rx_loader dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .data      (data),
      .load      (load),
      .frame_err (frame_err),
      .busy      (busy)
   );

   uart_rx_loader #(.N(5), .CLKS_PER_BIT(8)) dut5 (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx5),
      .data      (data5),
      .load      (load5),
      .frame_err (frame_err5),
      .busy      (busy5)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Strobe monitor for both instances.
   int         load_cnt = 0, ferr_cnt = 0, load_cyc = 0, proto_err = 0;
   int         load5_cnt = 0, ferr5_cnt = 0, load5_cyc = 0;
   logic [7:0] last_data = '0;
   logic [4:0] last5_data = '0;
   logic       load_prev = 1'b0, ferr_prev = 1'b0, load5_prev = 1'b0, ferr5_prev = 1'b0;

   always @(negedge clk) begin
      load_prev  <= load;
      ferr_prev  <= frame_err;
      load5_prev <= load5;
      ferr5_prev <= frame_err5;
      if (load === 1'b1) begin
         load_cnt  <= load_cnt + 1;
         last_data <= data;
         load_cyc  <= cyc;
      end
      if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
      if (load5 === 1'b1) begin
         load5_cnt  <= load5_cnt + 1;
         last5_data <= data5;
         load5_cyc  <= cyc;
      end
      if (frame_err5 === 1'b1) ferr5_cnt <= ferr5_cnt + 1;
      if ((load === 1'b1 && (frame_err === 1'b1 || load_prev === 1'b1 || busy === 1'b1)) ||
          (frame_err === 1'b1 && (ferr_prev === 1'b1 || busy === 1'b1)) ||
          (load5 === 1'b1 && (frame_err5 === 1'b1 || load5_prev === 1'b1)) ||
          (frame_err5 === 1'b1 && ferr5_prev === 1'b1))
         proto_err <= proto_err + 1;
   end

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   int fall_cyc = 0;

   // Called at a negedge; drives the line for one full frame and returns at the frame end.
   task automatic send(input logic [15:0] d, input int nbits, input int cpb, input logic stop,
                       input bit use5);
      if (use5) rx5 = 1'b0; else rx = 1'b0;
      fall_cyc = cyc;
      repeat (cpb) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         if (use5) rx5 = d[i]; else rx = d[i];
         repeat (cpb) @(negedge clk);
      end
      if (use5) rx5 = stop; else rx = stop;
      repeat (cpb) @(negedge clk);
      if (use5) rx5 = 1'b1; else rx = 1'b1;
   endtask

   typedef struct {
      logic [7:0] din;
      logic       stop_bit;
      logic       exp_load;
      logic       exp_ferr;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int l0, f0, n;
      bit seen;

      vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5};
      vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5};
      vecs[2] = '{8'h81, 1'b1, 1'b1, 1'b0, 8'h81};
      vecs[3] = '{8'h7E, 1'b0, 1'b0, 1'b1, 8'h81};

      repeat (3) @(negedge clk);
      check("rst_data", data, 8'h00);
      check("rst_load", load, 1'b0);
      check("rst_ferr", frame_err, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_data5", data5, 5'h00);
      check("rst_busy5", busy5, 1'b0);
      reset = 1'b0;
      repeat (10) @(negedge clk);

      for (int v = 0; v < 4; v++) begin
         l0 = load_cnt;
         f0 = ferr_cnt;
         send(16'(vecs[v].din), 8, 16, vecs[v].stop_bit, 1'b0);
         repeat (10) @(negedge clk);
         check($sformatf("vec%0d_loads", v), load_cnt - l0, 32'(vecs[v].exp_load));
         check($sformatf("vec%0d_ferrs", v), ferr_cnt - f0, 32'(vecs[v].exp_ferr));
         check($sformatf("vec%0d_data", v), data, vecs[v].exp_data);
         if (vecs[v].exp_load)
            check_range($sformatf("vec%0d_latency", v), load_cyc - fall_cyc, 153, 157);
      end

      // Short low glitch is rejected by the start-bit centre check.
      l0 = load_cnt;
      f0 = ferr_cnt;
      seen = 1'b0;
      rx = 1'b0;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 4) rx = 1'b1;
         if (busy) seen = 1'b1;
         if (seen && !busy && n == 0) n = i;
      end
      check("glitch_busy_seen", seen, 1'b1);
      check_range("glitch_busy_return", n, 1, 12);
      check("glitch_loads", load_cnt - l0, 0);
      check("glitch_ferrs", ferr_cnt - f0, 0);
      check("glitch_data", data, 8'h81);

      // Back-to-back frames with no idle gap.
      l0 = load_cnt;
      send(16'h0000, 8, 16, 1'b1, 1'b0);
      check("b2b_first_loads", load_cnt - l0, 1);
      check("b2b_first_data", last_data, 8'h00);
      send(16'h00FF, 8, 16, 1'b1, 1'b0);
      repeat (10) @(negedge clk);
      check("b2b_second_loads", load_cnt - l0, 2);
      check("b2b_second_data", data, 8'hFF);

      // Reset during bit 4 aborts the frame.
      l0 = load_cnt;
      f0 = ferr_cnt;
      rx = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = (i % 2 == 0);
         repeat (16) @(negedge clk);
      end
      rx = 1'b0;
      repeat (8) @(negedge clk);
      reset = 1'b1;
      rx = 1'b1;
      @(negedge clk);
      check("midrst_data", data, 8'h00);
      check("midrst_load", load, 1'b0);
      check("midrst_ferr", frame_err, 1'b0);
      check("midrst_busy", busy, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      repeat (200) @(negedge clk);
      check("midrst_no_strobe", (load_cnt - l0) + (ferr_cnt - f0), 0);
      send(16'h005A, 8, 16, 1'b1, 1'b0);
      repeat (10) @(negedge clk);
      check("after_rst_loads", load_cnt - l0, 1);
      check("after_rst_data", data, 8'h5A);

      // Narrow instance: N=5, 8 clocks per bit.
      l0 = load5_cnt;
      f0 = ferr5_cnt;
      send(16'h0013, 5, 8, 1'b1, 1'b1);
      repeat (10) @(negedge clk);
      check("n5_loads", load5_cnt - l0, 1);
      check("n5_ferrs", ferr5_cnt - f0, 0);
      check("n5_data", data5, 5'b10011);
      check_range("n5_latency", load5_cyc - fall_cyc, 53, 57);

      check("strobe_protocol", proto_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
